scrolling_text_buffer: RTL and testbench

Parametrised single-clock text-mode character store for the VGA path. It holds ROWS×COLS characters and supports direct (row, col) writes and a cursor-driven "put" stream with auto-advance and newline handling. Hardware scroll uses a rotating top-row offset with automatic blanking of the new bottom line, and a full-screen clear FSM. The host/CPU side writes; the VGA character generator reads through a registered read port.

---
 rtl/scrolling_text_buffer.sv | 176 +++++++++++++++++
 tb/tb_scrolling_text_buffer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/scrolling_text_buffer.sv
// Text-mode character store with cursor put stream, rotating-offset hardware scroll
// and full-screen / single-line blanking sweeps; registered read port for the VGA path.
module scrolling_text_buffer #(
  parameter int unsigned       ROWS   = 30,
  parameter int unsigned       COLS   = 80,
  parameter int unsigned       ROW_W  = 5,
  parameter int unsigned       COL_W  = 7,
  parameter int unsigned       CHAR_W = 8,
  parameter logic [CHAR_W-1:0] BLANK  = CHAR_W'(8'h20)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ROW_W-1:0]  wr_row,
  input  logic [COL_W-1:0]  wr_col,
  input  logic [CHAR_W-1:0] wr_char,
  input  logic              put_en,
  input  logic [CHAR_W-1:0] put_char,
  input  logic              scroll_en,
  input  logic              clear_en,
  input  logic [ROW_W-1:0]  rd_row,
  input  logic [COL_W-1:0]  rd_col,
  output logic [CHAR_W-1:0] rd_char,
  output logic              busy,
  output logic [ROW_W-1:0]  cursor_row,
  output logic [COL_W-1:0]  cursor_col
);

  localparam int unsigned       CELLS   = ROWS * COLS;
  localparam int unsigned       AW      = $clog2(CELLS);
  localparam logic [CHAR_W-1:0] NEWLINE = CHAR_W'(8'h0A);

  typedef enum logic [1:0] {IDLE, CLEAR_ALL, CLEAR_LINE} state_t;

  state_t            state;
  logic [ROW_W-1:0]  top;
  logic [AW-1:0]     cnt;
  logic [AW-1:0]     line_base;
  logic [CHAR_W-1:0] mem [CELLS];

  // Logical-to-physical row rotation; lrow must already be < ROWS.
  function automatic logic [ROW_W-1:0] phys_row(input logic [ROW_W-1:0] base,
                                                input logic [ROW_W-1:0] lrow);
    logic [ROW_W:0] sum;
    sum = {1'b0, base} + {1'b0, lrow};
    if (sum >= (ROW_W+1)'(ROWS)) sum = sum - (ROW_W+1)'(ROWS);
    return ROW_W'(sum);
  endfunction

  function automatic logic [AW-1:0] cell_addr(input logic [ROW_W-1:0] prow,
                                              input logic [COL_W-1:0] col);
    return AW'(prow) * AW'(COLS) + AW'(col);
  endfunction

  logic              rd_ok_c, wr_ok_c;
  logic              put_wrap_c, put_ovf_c;
  logic [ROW_W-1:0]  top_inc_c;
  logic [AW-1:0]     rd_addr_c;
  logic              mem_we_c;
  logic [AW-1:0]     mem_waddr_c;
  logic [CHAR_W-1:0] mem_wdata_c;

  assign rd_ok_c    = (32'(rd_row) < ROWS) && (32'(rd_col) < COLS);
  assign wr_ok_c    = (32'(wr_row) < ROWS) && (32'(wr_col) < COLS);
  assign rd_addr_c  = rd_ok_c ? cell_addr(phys_row(top, rd_row), rd_col) : '0;
  assign put_wrap_c = (put_char == NEWLINE) || (cursor_col == COL_W'(COLS - 1));
  assign put_ovf_c  = put_wrap_c && (cursor_row == ROW_W'(ROWS - 1));
  assign top_inc_c  = (top == ROW_W'(ROWS - 1)) ? '0 : top + 1'b1;

  // Single RAM write port: sweep blanking, cursor put, or direct write.
  always_comb begin
    mem_we_c    = 1'b0;
    mem_waddr_c = '0;
    mem_wdata_c = BLANK;
    case (state)
      CLEAR_ALL: begin
        mem_we_c    = 1'b1;
        mem_waddr_c = cnt;
      end
      CLEAR_LINE: begin
        mem_we_c    = 1'b1;
        mem_waddr_c = line_base + cnt;
      end
      default: begin
        if (!clear_en && !scroll_en) begin
          if (put_en) begin
            if (put_char != NEWLINE) begin
              mem_we_c    = 1'b1;
              mem_waddr_c = cell_addr(phys_row(top, cursor_row), cursor_col);
              mem_wdata_c = put_char;
            end
          end else if (wr_en && wr_ok_c) begin
            mem_we_c    = 1'b1;
            mem_waddr_c = cell_addr(phys_row(top, wr_row), wr_col);
            mem_wdata_c = wr_char;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (mem_we_c) mem[mem_waddr_c] <= mem_wdata_c;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_char <= '0;
    else        rd_char <= rd_ok_c ? mem[rd_addr_c] : BLANK;
  end

  // Command FSM; scroll (explicit or cursor overflow) blanks the old physical top row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= CLEAR_ALL;
      busy       <= 1'b1;
      top        <= '0;
      cnt        <= '0;
      line_base  <= '0;
      cursor_row <= '0;
      cursor_col <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (clear_en) begin
            top        <= '0;
            cursor_row <= '0;
            cursor_col <= '0;
            cnt        <= '0;
            state      <= CLEAR_ALL;
            busy       <= 1'b1;
          end else if (scroll_en || (put_en && put_ovf_c)) begin
            line_base <= cell_addr(top, '0);
            top       <= top_inc_c;
            cnt       <= '0;
            state     <= CLEAR_LINE;
            busy      <= 1'b1;
            if (!scroll_en) begin
              cursor_row <= ROW_W'(ROWS - 1);
              cursor_col <= '0;
            end
          end else if (put_en) begin
            if (put_wrap_c) begin
              cursor_row <= cursor_row + 1'b1;
              cursor_col <= '0;
            end else begin
              cursor_col <= cursor_col + 1'b1;
            end
          end
        end
        CLEAR_ALL: begin
          if (cnt == AW'(CELLS - 1)) begin
            cnt   <= '0;
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        CLEAR_LINE: begin
          if (cnt == AW'(COLS - 1)) begin
            cnt   <= '0;
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_scrolling_text_buffer.sv
// Scoreboard bench for scrolling_text_buffer: read expectations are queued at issue time
// and popped by a monitor one cycle later; control outputs are checked directly.
module tb_scrolling_text_buffer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_en = 1'b0;
  logic [4:0] wr_row = '0;
  logic [6:0] wr_col = '0;
  logic [7:0] wr_char = '0;
  logic       put_en = 1'b0;
  logic [7:0] put_char = '0;
  logic       scroll_en = 1'b0;
  logic       clear_en = 1'b0;
  logic [4:0] rd_row = '0;
  logic [6:0] rd_col = '0;
  logic [7:0] rd_char;
  logic       busy;
  logic [4:0] cursor_row;
  logic [6:0] cursor_col;

  scrolling_text_buffer dut (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col), .wr_char(wr_char),
    .put_en(put_en), .put_char(put_char),
    .scroll_en(scroll_en), .clear_en(clear_en),
    .rd_row(rd_row), .rd_col(rd_col), .rd_char(rd_char),
    .busy(busy), .cursor_row(cursor_row), .cursor_col(cursor_col)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         row;
    int         col;
    logic [7:0] exp;
  } rd_exp_t;

  rd_exp_t exp_q[$];
  int      n_vec  = 0;
  int      n_miss = 0;
  logic    rd_req = 1'b0;
  logic    rd_vld_d = 1'b0;

  always @(posedge clk) rd_vld_d <= rd_req;

  // Monitor: a read issued before edge N is visible after edge N.
  always @(negedge clk) begin : monitor
    rd_exp_t e;
    if (rd_vld_d) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_miss++;
        $display("FAIL read_scoreboard: data %h with no expectation queued", rd_char);
      end else begin
        e = exp_q.pop_front();
        if (rd_char !== e.exp) begin
          n_miss++;
          $display("FAIL read(%0d,%0d): got %h want %h", e.row, e.col, rd_char, e.exp);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic check_cursor(input string name, input int r, input int c);
    check({name, "_row"}, 32'(cursor_row), 32'(r));
    check({name, "_col"}, 32'(cursor_col), 32'(c));
  endtask

  task automatic issue_read(input int r, input int c, input logic [7:0] exp);
    rd_exp_t e;
    e.row = r; e.col = c; e.exp = exp;
    rd_row = 5'(r);
    rd_col = 7'(c);
    rd_req = 1'b1;
    exp_q.push_back(e);
    @(negedge clk);
    rd_req = 1'b0;
  endtask

  task automatic put(input logic [7:0] ch);
    put_en = 1'b1; put_char = ch;
    @(negedge clk);
    put_en = 1'b0;
  endtask

  task automatic wr(input int r, input int c, input logic [7:0] ch);
    wr_en = 1'b1; wr_row = 5'(r); wr_col = 7'(c); wr_char = ch;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // Counts cycles until busy falls; an expired bound shows up as a wrong count.
  task automatic wait_idle(input string name, input int exp_cycles);
    int n;
    n = 0;
    while (busy === 1'b1 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(n), 32'(exp_cycles));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset and power-on clear
    repeat (3) @(negedge clk);
    check("rst_rd_char", 32'(rd_char), 32'h0);
    check("rst_busy", 32'(busy), 32'h1);
    check_cursor("rst_cursor", 0, 0);
    rst_n = 1'b1;
    wait_idle("reset_sweep_cycles", 2400);
    check_cursor("post_reset_cursor", 0, 0);
    for (int r = 0; r < 30; r++)
      for (int c = 0; c < 80; c++)
        issue_read(r, c, 8'h20);

    // Direct writes, read-during-write, out-of-range drops
    wr_en = 1'b1; wr_row = 5'd14; wr_col = 7'd30; wr_char = 8'h41;
    issue_read(14, 30, 8'h20);
    wr_en = 1'b0;
    issue_read(14, 30, 8'h41);
    wr(14, 0, 8'h4A);
    wr(30, 0, 8'h55);
    wr(0, 80, 8'h55);
    issue_read(14, 0, 8'h4A);
    issue_read(1, 0, 8'h20);
    issue_read(13, 80, 8'h20);
    issue_read(30, 0, 8'h20);
    issue_read(31, 79, 8'h20);
    check_cursor("direct_cursor", 0, 0);

    // Cursor put stream with wrap and newline
    repeat (80) put(8'h41);
    check_cursor("put80_cursor", 1, 0);
    for (int c = 0; c < 80; c++) issue_read(0, c, 8'h41);
    repeat (5) put(8'h44);
    check_cursor("put5_cursor", 1, 5);
    put(8'h0A);
    check_cursor("newline_cursor", 2, 0);
    for (int c = 0; c < 5; c++) issue_read(1, c, 8'h44);
    issue_read(1, 5, 8'h20);

    // Explicit scroll
    wr(1, 0, 8'h42);
    scroll_en = 1'b1;
    @(negedge clk);
    scroll_en = 1'b0;
    check("scroll_busy_rise", 32'(busy), 32'h1);
    wait_idle("scroll_busy_cycles", 80);
    check_cursor("scroll_cursor", 2, 0);
    issue_read(0, 0, 8'h42);
    issue_read(0, 1, 8'h44);
    issue_read(13, 30, 8'h41);
    issue_read(13, 0, 8'h4A);
    for (int c = 0; c < 80; c++) issue_read(29, c, 8'h20);

    // Auto-scroll on cursor overflow
    repeat (27) put(8'h0A);
    check_cursor("nl27_cursor", 29, 0);
    repeat (79) put(8'h45);
    check_cursor("last_cell_cursor", 29, 79);
    put(8'h43);
    check("autoscroll_busy_rise", 32'(busy), 32'h1);
    check_cursor("autoscroll_cursor", 29, 0);
    wait_idle("autoscroll_busy_cycles", 80);
    issue_read(28, 79, 8'h43);
    issue_read(28, 0, 8'h45);
    issue_read(27, 0, 8'h20);
    issue_read(12, 30, 8'h41);
    for (int c = 0; c < 80; c++) issue_read(29, c, 8'h20);

    // Priority: clear beats put
    clear_en = 1'b1; put_en = 1'b1; put_char = 8'h47;
    @(negedge clk);
    clear_en = 1'b0; put_en = 1'b0;
    check_cursor("clear_vs_put_cursor", 0, 0);
    wait_idle("clear_busy_cycles", 2400);
    issue_read(12, 30, 8'h20);
    issue_read(0, 0, 8'h20);

    // Priority: scroll beats put; commands during busy are dropped
    scroll_en = 1'b1; put_en = 1'b1; put_char = 8'h41;
    @(negedge clk);
    scroll_en = 1'b0; put_en = 1'b0;
    check_cursor("scroll_vs_put_cursor", 0, 0);
    wr(3, 3, 8'h48);
    put(8'h41);
    check_cursor("busy_put_cursor", 0, 0);
    wait_idle("scroll2_busy_cycles", 78);
    issue_read(3, 3, 8'h20);
    issue_read(0, 0, 8'h20);

    // Priority: put beats direct write
    put_en = 1'b1; put_char = 8'h50;
    wr_en = 1'b1; wr_row = 5'd5; wr_col = 7'd5; wr_char = 8'h51;
    @(negedge clk);
    put_en = 1'b0; wr_en = 1'b0;
    check_cursor("put_vs_wr_cursor", 0, 1);
    issue_read(0, 0, 8'h50);
    issue_read(5, 5, 8'h20);

    // Reset pulse mid-sweep restarts the full clear
    clear_en = 1'b1;
    @(negedge clk);
    clear_en = 1'b0;
    repeat (1000) @(negedge clk);
    check("mid_sweep_busy", 32'(busy), 32'h1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_rd_char", 32'(rd_char), 32'h0);
    check("mid_rst_busy", 32'(busy), 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    wait_idle("mid_rst_sweep_cycles", 2400);
    check_cursor("mid_rst_cursor", 0, 0);
    issue_read(0, 0, 8'h20);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
